// File: rtl/winocnn_pkg.sv
// Shared types and constants for the Winograd CNN PE-array control path.
package winocnn_pkg;

    typedef enum logic {
        SIZE_1X1 = 1'b0,
        SIZE_3X3 = 1'b1
    } size_type_e;

    localparam int TILE_STEP_1X1 = 6;
    localparam int TILE_STEP_3X3 = 4;

    localparam int IDX_W = 9;
    localparam int OD_W  = 8;

    // One extra bit on the tile cursor so "origin >= H/W" is exact at the top edge.
    localparam int CUR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Spatial distance between consecutive tile origins for a kernel size.
    function automatic logic [2:0] tile_step(input size_type_e st);
        return (st == SIZE_3X3) ? 3'(TILE_STEP_3X3) : 3'(TILE_STEP_1X1);
    endfunction

endpackage

// File: rtl/pe_array_scheduler_tile_walker.sv
// Combinational raster stepper: expands the tile cursor into COLS consecutive
// tile origins (y fastest, then x) and reports where the next wave starts.
module tile_walker
    import winocnn_pkg::*;
#(
    parameter int COLS = 4
) (
    input  logic [CUR_W-1:0]            cur_x,
    input  logic [CUR_W-1:0]            cur_y,
    input  logic [2:0]                  step,
    input  logic [IDX_W-1:0]            h,
    input  logic [IDX_W-1:0]            w,
    output logic [COLS-1:0]             slot_valid,
    output logic [COLS-1:0][IDX_W-1:0]  slot_x,
    output logic [COLS-1:0][IDX_W-1:0]  slot_y,
    output logic [CUR_W-1:0]            next_x,
    output logic [CUR_W-1:0]            next_y,
    output logic                        exhausted
);

    logic [CUR_W-1:0] walk_x;
    logic [CUR_W-1:0] walk_y;

    // Step the cursor COLS times; a slot is live only while its row origin is inside H.
    always_comb begin
        walk_x     = cur_x;
        walk_y     = cur_y;
        slot_valid = '0;
        slot_x     = '0;
        slot_y     = '0;
        for (int s = 0; s < COLS; s++) begin
            slot_valid[s] = (walk_x < CUR_W'(h));
            slot_x[s]     = walk_x[IDX_W-1:0];
            slot_y[s]     = walk_y[IDX_W-1:0];
            walk_y        = walk_y + CUR_W'(step);
            if (walk_y >= CUR_W'(w)) begin
                walk_y = '0;
                walk_x = walk_x + CUR_W'(step);
            end
        end
        next_x    = walk_x;
        next_y    = walk_y;
        exhausted = (walk_x >= CUR_W'(h));
    end

endmodule

// File: rtl/pe_array_scheduler.sv
// Wave scheduler for the ROWS x COLS systolic Winograd PE array. Each launched
// wave pairs COLS data tiles with ROWS output depths; skewed delay lines make
// data and weights of a wave meet in every PE on the same cycle.
module pe_array_scheduler
    import winocnn_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int DRAIN_EXTRA = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [IDX_W-1:0]       cfg_h_i,
    input  logic [IDX_W-1:0]       cfg_w_i,
    input  logic [OD_W-1:0]        cfg_od_i,
    input  logic                   cfg_size_type_i,
    input  logic                   feed_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [COLS-1:0]        col_valid_o,
    output logic [COLS*IDX_W-1:0]  col_x_o,
    output logic [COLS*IDX_W-1:0]  col_y_o,
    output logic [ROWS-1:0]        row_valid_o,
    output logic [ROWS*OD_W-1:0]   row_od_o,
    output logic                   size_type_o
);

    localparam int                DRAIN_LEN  = ((ROWS > COLS) ? ROWS : COLS) + DRAIN_EXTRA;
    localparam int                ODX_W      = OD_W + 1;
    localparam logic [ODX_W-1:0]  ROWS_X     = ODX_W'(ROWS);
    localparam logic [7:0]        DRAIN_LOAD = 8'(DRAIN_LEN - 1);

    sched_state_t state, next_state;

    logic [IDX_W-1:0] h_q;
    logic [IDX_W-1:0] w_q;
    logic [OD_W-1:0]  od_q;
    logic [2:0]       step_q;
    logic [CUR_W-1:0] cur_x;
    logic [CUR_W-1:0] cur_y;
    logic [ODX_W-1:0] od_base;
    logic [7:0]       drain_cnt;

    logic                        launch;
    logic                        last_wave;
    logic                        start_degenerate;
    logic [COLS-1:0]             slot_valid;
    logic [COLS-1:0][IDX_W-1:0]  slot_x;
    logic [COLS-1:0][IDX_W-1:0]  slot_y;
    logic [CUR_W-1:0]            next_x;
    logic [CUR_W-1:0]            next_y;
    logic                        exhausted;
    logic [ROWS-1:0]             row_slot_valid;
    logic [ROWS-1:0][OD_W-1:0]   row_slot_od;

    assign start_degenerate = (cfg_h_i == '0) || (cfg_w_i == '0) || (cfg_od_i == '0);

    tile_walker #(
        .COLS (COLS)
    ) u_walker (
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .step       (step_q),
        .h          (h_q),
        .w          (w_q),
        .slot_valid (slot_valid),
        .slot_x     (slot_x),
        .slot_y     (slot_y),
        .next_x     (next_x),
        .next_y     (next_y),
        .exhausted  (exhausted)
    );

    // Each row of the current od group carries od_base + r while that depth exists.
    always_comb begin
        row_slot_valid = '0;
        row_slot_od    = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_slot_valid[r] = (od_base + ODX_W'(r)) < {1'b0, od_q};
            row_slot_od[r]    = OD_W'(od_base + ODX_W'(r));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the launch / last-wave decisions for this cycle.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        last_wave  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = start_degenerate ? DRAIN : RUN;
                end
            end
            RUN: begin
                launch    = feed_ready_i;
                last_wave = feed_ready_i && exhausted && ((od_base + ROWS_X) >= {1'b0, od_q});
                if (last_wave) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Layer configuration, loop cursors, drain timer and busy/done flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q         <= '0;
            w_q         <= '0;
            od_q        <= '0;
            step_q      <= '0;
            size_type_o <= 1'b0;
            cur_x       <= '0;
            cur_y       <= '0;
            od_base     <= '0;
            drain_cnt   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        h_q         <= cfg_h_i;
                        w_q         <= cfg_w_i;
                        od_q        <= cfg_od_i;
                        step_q      <= tile_step(size_type_e'(cfg_size_type_i));
                        size_type_o <= cfg_size_type_i;
                        cur_x       <= '0;
                        cur_y       <= '0;
                        od_base     <= '0;
                        drain_cnt   <= '0;
                        busy_o      <= 1'b1;
                    end
                end
                RUN: begin
                    if (launch) begin
                        if (exhausted) begin
                            cur_x   <= '0;
                            cur_y   <= '0;
                            od_base <= od_base + ROWS_X;
                        end else begin
                            cur_x <= next_x;
                            cur_y <= next_y;
                        end
                        if (last_wave) begin
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [c:0]            v_pipe;
        logic [c:0][IDX_W-1:0] x_pipe;
        logic [c:0][IDX_W-1:0] y_pipe;

        // Column c delay line: launch register plus c skew stages; dead slots carry zeros.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v_pipe <= '0;
                x_pipe <= '0;
                y_pipe <= '0;
            end else begin
                v_pipe[0] <= launch && slot_valid[c];
                x_pipe[0] <= (launch && slot_valid[c]) ? slot_x[c] : '0;
                y_pipe[0] <= (launch && slot_valid[c]) ? slot_y[c] : '0;
                for (int k = 1; k <= c; k++) begin
                    v_pipe[k] <= v_pipe[k-1];
                    x_pipe[k] <= x_pipe[k-1];
                    y_pipe[k] <= y_pipe[k-1];
                end
            end
        end

        assign col_valid_o[c]              = v_pipe[c];
        assign col_x_o[c*IDX_W +: IDX_W]   = x_pipe[c];
        assign col_y_o[c*IDX_W +: IDX_W]   = y_pipe[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [r:0]           v_pipe;
        logic [r:0][OD_W-1:0] od_pipe;

        // Row r delay line: launch register plus r skew stages; dead slots carry zeros.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v_pipe  <= '0;
                od_pipe <= '0;
            end else begin
                v_pipe[0]  <= launch && row_slot_valid[r];
                od_pipe[0] <= (launch && row_slot_valid[r]) ? row_slot_od[r] : '0;
                for (int k = 1; k <= r; k++) begin
                    v_pipe[k]  <= v_pipe[k-1];
                    od_pipe[k] <= od_pipe[k-1];
                end
            end
        end

        assign row_valid_o[r]            = v_pipe[r];
        assign row_od_o[r*OD_W +: OD_W]  = od_pipe[r];
    end

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Self-checking bench for pe_array_scheduler: fixed table of layers with
// hand-derived aggregates, randomized layers, and a mid-run reset sequence,
// all compared cycle by cycle against a list-based wave model.
module tb_pe_array_scheduler;

    localparam int ROWS        = 4;
    localparam int COLS        = 4;
    localparam int DRAIN_EXTRA = 2;
    localparam int DLEN        = ((ROWS > COLS) ? ROWS : COLS) + DRAIN_EXTRA;
    localparam int MAXC        = 400;

    logic                  clk;
    logic                  reset;
    logic                  start_i;
    logic [8:0]            cfg_h_i;
    logic [8:0]            cfg_w_i;
    logic [7:0]            cfg_od_i;
    logic                  cfg_size_type_i;
    logic                  feed_ready_i;
    logic                  busy_o;
    logic                  done_o;
    logic [COLS-1:0]       col_valid_o;
    logic [COLS*9-1:0]     col_x_o;
    logic [COLS*9-1:0]     col_y_o;
    logic [ROWS-1:0]       row_valid_o;
    logic [ROWS*8-1:0]     row_od_o;
    logic                  size_type_o;

    int   n_checks  = 0;
    int   n_errors  = 0;
    logic last_type = 1'b0;

    bit              rdy   [MAXC];
    logic [COLS-1:0] e_cv  [MAXC];
    logic [COLS*9-1:0] e_cx [MAXC];
    logic [COLS*9-1:0] e_cy [MAXC];
    logic [ROWS-1:0] e_rv  [MAXC];
    logic [ROWS*8-1:0] e_rod [MAXC];
    bit              e_busy[MAXC];
    bit              e_done[MAXC];
    int              m_done_cycle;

    typedef struct {
        int              h;
        int              w;
        int              od;
        int              typ;
        int              bub_at;
        int              bub_len;
        int              exp_done;
        logic [COLS-1:0] exp_mask;
        int              exp_col_hits;
        int              exp_row_hits;
    } vec_t;

    pe_array_scheduler #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .DRAIN_EXTRA (DRAIN_EXTRA)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .cfg_h_i         (cfg_h_i),
        .cfg_w_i         (cfg_w_i),
        .cfg_od_i        (cfg_od_i),
        .cfg_size_type_i (cfg_size_type_i),
        .feed_ready_i    (feed_ready_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .col_valid_o     (col_valid_o),
        .col_x_o         (col_x_o),
        .col_y_o         (col_y_o),
        .row_valid_o     (row_valid_o),
        .row_od_o        (row_od_o),
        .size_type_o     (size_type_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string what, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", what, act, exp);
        end
    endtask

    // Ready pattern per cycle index (cycle 0 is the start cycle).
    task automatic fill_ready(input int bub_at, input int bub_len, input bit rnd);
        for (int i = 0; i < MAXC; i++) begin
            if (rnd) rdy[i] = ($urandom_range(0, 3) != 0);
            else     rdy[i] = !((i >= bub_at) && (i < bub_at + bub_len));
        end
    endtask

    // Reference: enumerate raster tiles and od groups, then place each wave's
    // slots on the cycles implied by the ready pattern and the skew.
    task automatic build_model(input int h, input int w, input int od, input logic typ);
        int tx[$];
        int ty[$];
        int launches[$];
        int step, ntiles, ntw, ngr, nw, g, t, idx, o, cyc;
        for (int i = 0; i < MAXC; i++) begin
            e_cv[i] = '0; e_cx[i] = '0; e_cy[i] = '0;
            e_rv[i] = '0; e_rod[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
        end
        step = typ ? 4 : 6;
        for (int x = 0; x < h; x += step)
            for (int y = 0; y < w; y += step) begin
                tx.push_back(x);
                ty.push_back(y);
            end
        ntiles = tx.size();
        ntw    = (ntiles + COLS - 1) / COLS;
        ngr    = (od + ROWS - 1) / ROWS;
        nw     = ntw * ngr;
        if (nw == 0) begin
            m_done_cycle = 2;
        end else begin
            for (int i = 1; i < MAXC - 16 && launches.size() < nw; i++)
                if (rdy[i]) launches.push_back(i);
            if (launches.size() < nw) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL launch_budget: actual=%0d required=%0d", launches.size(), nw);
                m_done_cycle = MAXC - 2;
            end else begin
                for (int k = 0; k < nw; k++) begin
                    g = k / ntw;
                    t = k % ntw;
                    for (int c = 0; c < COLS; c++) begin
                        idx = t * COLS + c;
                        cyc = launches[k] + 1 + c;
                        if (idx < ntiles) begin
                            e_cv[cyc][c]        = 1'b1;
                            e_cx[cyc][c*9 +: 9] = 9'(tx[idx]);
                            e_cy[cyc][c*9 +: 9] = 9'(ty[idx]);
                        end
                    end
                    for (int r = 0; r < ROWS; r++) begin
                        o   = g * ROWS + r;
                        cyc = launches[k] + 1 + r;
                        if (o < od) begin
                            e_rv[cyc][r]         = 1'b1;
                            e_rod[cyc][r*8 +: 8] = 8'(o);
                        end
                    end
                end
                m_done_cycle = launches[nw-1] + 1 + DLEN;
            end
        end
        for (int i = 1; i < m_done_cycle; i++) e_busy[i] = 1'b1;
        e_done[m_done_cycle] = 1'b1;
    endtask

    task automatic check_output(input int i, input logic typ);
        check($sformatf("cols@%0d", i), 128'({col_valid_o, col_x_o, col_y_o}), 128'({e_cv[i], e_cx[i], e_cy[i]}));
        check($sformatf("rows@%0d", i), 128'({row_valid_o, row_od_o}), 128'({e_rv[i], e_rod[i]}));
        check($sformatf("busy_done@%0d", i), 128'({busy_o, done_o}), 128'({e_busy[i], e_done[i]}));
        check($sformatf("size_type@%0d", i), 128'(size_type_o), 128'((i == 0) ? last_type : typ));
    endtask

    // Cycle 0 carries the real start; busy cycles get spurious starts with junk config.
    task automatic apply_stimulus(input int i, input int h, input int w, input int od,
                                  input logic typ, input bit spur);
        feed_ready_i = rdy[i];
        if (i == 0) begin
            start_i         = 1'b1;
            cfg_h_i         = 9'(h);
            cfg_w_i         = 9'(w);
            cfg_od_i        = 8'(od);
            cfg_size_type_i = typ;
        end else begin
            start_i         = (i < m_done_cycle) && ((i == 1) || (spur && ($urandom_range(0, 3) == 0)));
            cfg_h_i         = 9'($urandom_range(0, 511));
            cfg_w_i         = 9'($urandom_range(0, 511));
            cfg_od_i        = 8'($urandom_range(0, 255));
            cfg_size_type_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_layer(input int h, input int w, input int od, input logic typ,
                             input int abort_at, input bit spur,
                             output int obs_done, output logic [COLS-1:0] obs_mask,
                             output int obs_col, output int obs_row);
        int len;
        build_model(h, w, od, typ);
        len      = (abort_at >= 0) ? abort_at : m_done_cycle + 1;
        obs_done = -1;
        obs_mask = '0;
        obs_col  = 0;
        obs_row  = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check_output(i, typ);
            if (done_o && obs_done < 0) obs_done = i;
            obs_mask |= col_valid_o;
            obs_col  += $countones(col_valid_o);
            obs_row  += $countones(row_valid_o);
            apply_stimulus(i, h, w, od, typ, spur);
        end
        if (abort_at < 0) last_type = typ;
    endtask

    initial begin
        vec_t            vecs[8];
        int              o_done, o_col, o_row;
        logic [COLS-1:0] o_mask;
        int              rh, rw, rod;
        logic            rtyp;

        // h, w, od, type, bubble start, bubble length, done cycle, col mask, col hits, row hits
        vecs[0] = '{8,  8,  4, 1, 0, 0,  8, 4'b1111,  4,  4};
        vecs[1] = '{12, 12, 6, 0, 0, 0,  9, 4'b1111,  8,  6};
        vecs[2] = '{8,  4,  4, 1, 0, 0,  8, 4'b0011,  2,  4};
        vecs[3] = '{12, 12, 6, 0, 2, 3, 12, 4'b1111,  8,  6};
        vecs[4] = '{8,  8,  0, 1, 0, 0,  2, 4'b0000,  0,  0};
        vecs[5] = '{5,  0,  9, 0, 0, 0,  2, 4'b0000,  0,  0};
        vecs[6] = '{13, 5,  5, 1, 0, 0, 11, 4'b1111, 16, 10};
        vecs[7] = '{1,  1,  1, 0, 0, 0,  8, 4'b0001,  1,  1};

        reset           = 1'b0;
        start_i         = 1'b0;
        cfg_h_i         = '0;
        cfg_w_i         = '0;
        cfg_od_i        = '0;
        cfg_size_type_i = 1'b0;
        feed_ready_i    = 1'b0;

        #1;
        check("reset_state", 128'({busy_o, done_o, col_valid_o, row_valid_o, size_type_o, col_x_o, col_y_o, row_od_o}), 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[v]) begin
            fill_ready(vecs[v].bub_at, vecs[v].bub_len, 1'b0);
            run_layer(vecs[v].h, vecs[v].w, vecs[v].od, 1'(vecs[v].typ), -1, 1'b0,
                      o_done, o_mask, o_col, o_row);
            check($sformatf("v%0d done_cycle", v), 128'(o_done), 128'(vecs[v].exp_done));
            check($sformatf("v%0d col_mask", v), 128'(o_mask), 128'(vecs[v].exp_mask));
            check($sformatf("v%0d col_hits", v), 128'(o_col), 128'(vecs[v].exp_col_hits));
            check($sformatf("v%0d row_hits", v), 128'(o_row), 128'(vecs[v].exp_row_hits));
        end

        for (int n = 0; n < 14; n++) begin
            rh   = $urandom_range(1, 20);
            rw   = $urandom_range(1, 20);
            rod  = $urandom_range(1, 14);
            rtyp = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rod = 0;
            if ($urandom_range(0, 9) == 0) rh = 0;
            fill_ready(0, 0, 1'b1);
            run_layer(rh, rw, rod, rtyp, -1, 1'b1, o_done, o_mask, o_col, o_row);
        end

        // Reset in the middle of a long layer, then replay a known layer from scratch.
        fill_ready(0, 0, 1'b0);
        run_layer(24, 24, 8, 1'b1, 6, 1'b0, o_done, o_mask, o_col, o_row);
        @(posedge clk);
        #3;
        reset        = 1'b0;
        start_i      = 1'b0;
        feed_ready_i = 1'b0;
        #1;
        check("abort_async_clear", 128'({col_valid_o, row_valid_o, busy_o, done_o, col_x_o, col_y_o, row_od_o}), 128'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort_hold@%0d", i), 128'({col_valid_o, row_valid_o, busy_o, done_o}), 128'(0));
        end
        reset     = 1'b1;
        last_type = 1'b0;
        fill_ready(0, 0, 1'b0);
        run_layer(12, 12, 6, 1'b0, -1, 1'b0, o_done, o_mask, o_col, o_row);
        check("replay done_cycle", 128'(o_done), 128'(9));
        check("replay row_hits", 128'(o_row), 128'(6));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
